// File: rtl/imem_loader.sv
// Streams a length-prefixed byte program into instruction memory, holding the core in reset until done.
// Optional trailer checksum (running XOR) is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              byte_valid_i,
   input  logic [7:0]        byte_data_i,
   output logic              byte_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_waddr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              core_rst_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   // Counters need one bit beyond the address so a full 2^ADDR_W load is representable.
   localparam int CNT_W = (ADDR_W + 1 > 9) ? ADDR_W + 1 : 9;

   typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, DONE} state_t;

   state_t             state_reg;
   logic [CNT_W-1:0]   len_reg;
   logic [CNT_W-1:0]   word_cnt_reg;
   logic [1:0]         byte_cnt_reg;
   logic [23:0]        shift_reg;
   logic               we_reg;
   logic [ADDR_W-1:0]  waddr_reg;
   logic [31:0]        wdata_reg;
   logic               core_rst_reg;
   logic               done_reg;
   logic               last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]         csum_reg;
   logic               err_reg;
`endif

   assign last_word = (word_cnt_reg + CNT_W'(1)) == len_reg;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg    <= IDLE;
         len_reg      <= '0;
         word_cnt_reg <= '0;
         byte_cnt_reg <= '0;
         shift_reg    <= '0;
         we_reg       <= 1'b0;
         waddr_reg    <= '0;
         wdata_reg    <= '0;
         core_rst_reg <= 1'b1;
         done_reg     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         csum_reg     <= '0;
         err_reg      <= 1'b0;
`endif
      end else begin
         we_reg <= 1'b0;
         case (state_reg)
            IDLE, DONE: begin
               if (start_i) begin
                  state_reg    <= LEN;
                  core_rst_reg <= 1'b1;
                  done_reg     <= 1'b0;
                  word_cnt_reg <= '0;
                  byte_cnt_reg <= '0;
                  shift_reg    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_reg     <= '0;
                  err_reg      <= 1'b0;
`endif
               end
            end
            LEN: begin
               if (byte_valid_i) begin
                  len_reg   <= (byte_data_i == 8'd0) ? (CNT_W'(1) << ADDR_W) : CNT_W'(byte_data_i);
                  state_reg <= DATA;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_reg  <= byte_data_i;
`endif
               end
            end
            DATA: begin
               if (byte_valid_i) begin
                  byte_cnt_reg <= byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                  csum_reg     <= csum_reg ^ byte_data_i;
`endif
                  if (byte_cnt_reg == 2'd3) begin
                     // Earlier bytes have been shifted down to the low lanes: little-endian word.
                     we_reg       <= 1'b1;
                     waddr_reg    <= word_cnt_reg[ADDR_W-1:0];
                     wdata_reg    <= {byte_data_i, shift_reg};
                     word_cnt_reg <= word_cnt_reg + CNT_W'(1);
                     if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_reg    <= CSUM;
`else
                        state_reg    <= DONE;
                        done_reg     <= 1'b1;
                        core_rst_reg <= 1'b0;
`endif
                     end
                  end else begin
                     shift_reg <= {byte_data_i, shift_reg[23:8]};
                  end
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM: begin
               if (byte_valid_i) begin
                  state_reg <= DONE;
                  if (byte_data_i == csum_reg) begin
                     done_reg     <= 1'b1;
                     core_rst_reg <= 1'b0;
                  end else begin
                     err_reg <= 1'b1;
                  end
               end
            end
`endif
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign byte_ready_o = (state_reg == LEN) || (state_reg == DATA) || (state_reg == CSUM);
   assign busy_o       = byte_ready_o;
   assign imem_we_o    = we_reg;
   assign imem_waddr_o = waddr_reg;
   assign imem_wdata_o = wdata_reg;
   assign core_rst_o   = core_rst_reg;
   assign done_o       = done_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
   assign err_o        = err_reg;
`else
   assign err_o        = 1'b0;
`endif

endmodule
